// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 registered demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_sel_t;

  localparam ch_sel_t CH1 = 2'b00;
  localparam ch_sel_t CH2 = 2'b01;
  localparam ch_sel_t CH3 = 2'b10;
  localparam ch_sel_t CH4 = 2'b11;

  // One-hot channel strobe for a select code; bit k drives slot k.
  function automatic logic [NUM_CH-1:0] sel_decode(input ch_sel_t sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_if.sv
// Input handshake, four channel outputs and debug counters of the demultiplexer.
interface demux_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0]  in_data;
  ch_sel_t           in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out1;
  logic [WIDTH-1:0]  out2;
  logic [WIDTH-1:0]  out3;
  logic [WIDTH-1:0]  out4;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [CNT_W-1:0]  xfer_cnt1;
  logic [CNT_W-1:0]  xfer_cnt2;
  logic [CNT_W-1:0]  xfer_cnt3;
  logic [CNT_W-1:0]  xfer_cnt4;

  // master: producer plus channel consumers; slave: the demultiplexer itself
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out1, out2, out3, out4, out_valid,
    input  xfer_cnt1, xfer_cnt2, xfer_cnt3, xfer_cnt4
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out1, out2, out3, out4, out_valid,
    output xfer_cnt1, xfer_cnt2, xfer_cnt3, xfer_cnt4
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready drain side and a wrapping
// count of words handed to the consumer.
module demux_slot #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             drain;

  // A load on the same edge as a drain wins the valid bit, so the slot
  // stays full; the counter still records the word that left.
  always_comb begin
    drain      = valid_reg && drain_ready;
    data_next  = data_reg;
    valid_next = valid_reg && !drain;
    cnt_next   = cnt_reg + CNT_W'(drain);
    if (load) begin
      data_next  = load_data;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
  assign cnt   = cnt_reg;

endmodule

// File: rtl/demultiplexer.sv
// 1-to-4 registered demultiplexer: steers each accepted word into the
// holding slot named by in_sel; each slot drains on its own handshake.
module demultiplexer
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  demux_if.slave  bus
);

  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] slot_load;
  logic [NUM_CH-1:0] slot_valid;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic [CNT_W-1:0]  slot_cnt  [NUM_CH];
  logic              in_ready_int;

  // Ready looks only at the addressed slot, so a stalled channel never
  // holds up words bound for the others.
  assign sel_oh       = sel_decode(bus.in_sel);
  assign in_ready_int = !slot_valid[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign slot_load    = (bus.in_valid && in_ready_int) ? sel_oh : '0;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (slot_load[gi]),
        .load_data   (bus.in_data),
        .drain_ready (bus.out_ready[gi]),
        .data        (slot_data[gi]),
        .valid       (slot_valid[gi]),
        .cnt         (slot_cnt[gi])
      );
    end
  endgenerate

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = slot_valid;
  assign bus.out1      = slot_data[CH1];
  assign bus.out2      = slot_data[CH2];
  assign bus.out3      = slot_data[CH3];
  assign bus.out4      = slot_data[CH4];
  assign bus.xfer_cnt1 = slot_cnt[CH1];
  assign bus.xfer_cnt2 = slot_cnt[CH2];
  assign bus.xfer_cnt3 = slot_cnt[CH3];
  assign bus.xfer_cnt4 = slot_cnt[CH4];

endmodule

// File: tb/tb_demultiplexer.sv
// Directed, table-driven bench for the demultiplexer: routing, backpressure,
// drain+fill, counter wrap and asynchronous reset.
module tb_demultiplexer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  demux_if #(.WIDTH(4), .CNT_W(8)) bus ();

  demultiplexer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0] data;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] e1, e2, e3, e4;
    logic [3:0] eov;
    logic [7:0] c1, c2, c3, c4;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [3:0] e1, e2, e3, e4,
                         input logic [3:0] eov,
                         input logic [7:0] c1, c2, c3, c4);
    chk("out1", idx, 32'(bus.out1), 32'(e1));
    chk("out2", idx, 32'(bus.out2), 32'(e2));
    chk("out3", idx, 32'(bus.out3), 32'(e3));
    chk("out4", idx, 32'(bus.out4), 32'(e4));
    chk("out_valid", idx, 32'(bus.out_valid), 32'(eov));
    chk("xfer_cnt1", idx, 32'(bus.xfer_cnt1), 32'(c1));
    chk("xfer_cnt2", idx, 32'(bus.xfer_cnt2), 32'(c2));
    chk("xfer_cnt3", idx, 32'(bus.xfer_cnt3), 32'(c3));
    chk("xfer_cnt4", idx, 32'(bus.xfer_cnt4), 32'(c4));
  endtask

  vec_t vecs [15];

  initial begin
    // routing, all consumers ready
    vecs[0]  = '{4'h8, 2'd0, 1'b1, 4'hF, 1'b1, 4'h8, 4'h0, 4'h0, 4'h0, 4'b0001, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[1]  = '{4'h4, 2'd1, 1'b1, 4'hF, 1'b1, 4'h8, 4'h4, 4'h0, 4'h0, 4'b0010, 8'd1, 8'd0, 8'd0, 8'd0};
    vecs[2]  = '{4'h2, 2'd2, 1'b1, 4'hF, 1'b1, 4'h8, 4'h4, 4'h2, 4'h0, 4'b0100, 8'd1, 8'd1, 8'd0, 8'd0};
    vecs[3]  = '{4'h1, 2'd3, 1'b1, 4'hF, 1'b1, 4'h8, 4'h4, 4'h2, 4'h1, 4'b1000, 8'd1, 8'd1, 8'd1, 8'd0};
    vecs[4]  = '{4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h8, 4'h4, 4'h2, 4'h1, 4'b0000, 8'd1, 8'd1, 8'd1, 8'd1};
    // backpressure on channel 1, channel 2 keeps flowing
    vecs[5]  = '{4'hA, 2'd0, 1'b1, 4'hE, 1'b1, 4'hA, 4'h4, 4'h2, 4'h1, 4'b0001, 8'd1, 8'd1, 8'd1, 8'd1};
    vecs[6]  = '{4'hB, 2'd0, 1'b1, 4'hE, 1'b0, 4'hA, 4'h4, 4'h2, 4'h1, 4'b0001, 8'd1, 8'd1, 8'd1, 8'd1};
    vecs[7]  = '{4'hC, 2'd1, 1'b1, 4'hE, 1'b1, 4'hA, 4'hC, 4'h2, 4'h1, 4'b0011, 8'd1, 8'd1, 8'd1, 8'd1};
    vecs[8]  = '{4'hB, 2'd0, 1'b1, 4'hF, 1'b1, 4'hB, 4'hC, 4'h2, 4'h1, 4'b0001, 8'd2, 8'd2, 8'd1, 8'd1};
    vecs[9]  = '{4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'hB, 4'hC, 4'h2, 4'h1, 4'b0000, 8'd3, 8'd2, 8'd1, 8'd1};
    // drain+fill of the same slot
    vecs[10] = '{4'h5, 2'd0, 1'b1, 4'hE, 1'b1, 4'h5, 4'hC, 4'h2, 4'h1, 4'b0001, 8'd3, 8'd2, 8'd1, 8'd1};
    vecs[11] = '{4'h6, 2'd0, 1'b1, 4'hF, 1'b1, 4'h6, 4'hC, 4'h2, 4'h1, 4'b0001, 8'd4, 8'd2, 8'd1, 8'd1};
    // ready low with in_valid low; then drain; then idle with sel ignored
    vecs[12] = '{4'h0, 2'd0, 1'b0, 4'hE, 1'b0, 4'h6, 4'hC, 4'h2, 4'h1, 4'b0001, 8'd4, 8'd2, 8'd1, 8'd1};
    vecs[13] = '{4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h6, 4'hC, 4'h2, 4'h1, 4'b0000, 8'd5, 8'd2, 8'd1, 8'd1};
    vecs[14] = '{4'h7, 2'd2, 1'b0, 4'h0, 1'b1, 4'h6, 4'hC, 4'h2, 4'h1, 4'b0000, 8'd5, 8'd2, 8'd1, 8'd1};

    // T1: reset asserted before any clock edge clears everything at once
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    #3;
    chk_all(100, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    chk("in_ready_rst", 100, 32'(bus.in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table: drive, check combinational ready, clock, check registered state
    for (int i = 0; i < 15; i++) begin
      bus.in_data   = vecs[i].data;
      bus.in_sel    = vecs[i].sel;
      bus.in_valid  = vecs[i].valid;
      bus.out_ready = vecs[i].ordy;
      #1;
      chk("in_ready", i, 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4, vecs[i].eov,
              vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].c4);
      $display("vec %0d: sel=%0d data=%h valid=%b ordy=%b -> out_valid=%b", i,
               vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].ordy, bus.out_valid);
    end

    // T5: 256 words to channel 3; its counter starts at 1 and must wrap back
    bus.out_ready = 4'hF;
    bus.in_sel    = 2'd2;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in_data = 4'(i);
      #1;
      chk("in_ready_wrap", i, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    // 255 drains so far: 1 + 255 wraps to 0
    chk_all(200, 4'h6, 4'hC, 4'hF, 4'h1, 4'b0100, 8'd5, 8'd2, 8'd0, 8'd1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all(201, 4'h6, 4'hC, 4'hF, 4'h1, 4'b0000, 8'd5, 8'd2, 8'd1, 8'd1);
    $display("wrap: 256 words on ch3, xfer_cnt3=%0d", bus.xfer_cnt3);

    // T6: fill slots 1 and 2 with consumers stalled, then reset mid-cycle
    bus.out_ready = 4'b1100;
    bus.in_sel    = 2'd0;
    bus.in_data   = 4'h3;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_sel  = 2'd1;
    bus.in_data = 4'h9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    #1;
    chk_all(300, 4'h3, 4'h9, 4'hF, 4'h1, 4'b0011, 8'd5, 8'd2, 8'd1, 8'd1);
    chk("in_ready_full", 300, 32'(bus.in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all(301, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    chk("in_ready_rst", 301, 32'(bus.in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 4'hF;
    bus.in_sel    = 2'd3;
    bus.in_data   = 4'hE;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk_all(302, 4'h0, 4'h0, 4'h0, 4'hE, 4'b1000, 8'd0, 8'd0, 8'd0, 8'd0);
    @(posedge clk);
    #1;
    chk_all(303, 4'h0, 4'h0, 4'h0, 4'hE, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd1);
    $display("post-reset word on ch4: out4=%h xfer_cnt4=%0d", bus.out4, bus.xfer_cnt4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
